// File: rtl/alu_wb_sequencer.sv
// rtl/alu_wb_sequencer.sv - four-state ALU sequencer driving a RegisterFile read/write port set
// Optional feature: ALU_SEQ_R0_ZERO_EN makes register 0 read as zero and suppresses its writes.
module alu_wb_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_SLT = 3'd5, OP_LI  = 3'd6, OP_MOV = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd, r_ra1, r_ra2, r_wa3;
    logic [DATA_W-1:0] r_imm, r_a, r_b, r_wd3, r_result;
    logic              r_in_ready, r_we3, r_done, r_carry, r_zero, r_carry_pend;

    logic [DATA_W:0]   w_alu;
    logic              w_carry;
    logic [DATA_W-1:0] w_opa, w_opb;
    logic              w_we;

`ifdef ALU_SEQ_R0_ZERO_EN
    assign w_opa = (r_ra1 == '0) ? '0 : rd1;
    assign w_opb = (r_ra2 == '0) ? '0 : rd2;
    assign w_we  = (r_rd != '0);
`else
    assign w_opa = rd1;
    assign w_opb = rd2;
    assign w_we  = 1'b1;
`endif

    // Extra top bit carries the ADD carry-out or the SUB borrow.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, r_b};
            OP_AND:  w_alu = {1'b0, r_a & r_b};
            OP_OR:   w_alu = {1'b0, r_a | r_b};
            OP_XOR:  w_alu = {1'b0, r_a ^ r_b};
            OP_SLT:  w_alu = {{DATA_W{1'b0}}, (r_a < r_b)};
            OP_LI:   w_alu = {1'b0, r_imm};
            OP_MOV:  w_alu = {1'b0, r_a};
            default: w_alu = '0;
        endcase
        w_carry = ((r_op == OP_ADD) || (r_op == OP_SUB)) && w_alu[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_op         <= '0;
            r_rd         <= '0;
            r_imm        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_ra1        <= '0;
            r_ra2        <= '0;
            r_wa3        <= '0;
            r_wd3        <= '0;
            r_we3        <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
            r_carry      <= 1'b0;
            r_carry_pend <= 1'b0;
            r_zero       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_rd       <= rd;
                        r_imm      <= imm;
                        r_ra1      <= rs1;
                        r_ra2      <= rs2;
                        r_in_ready <= 1'b0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= w_opa;
                    r_b     <= w_opb;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_wd3        <= w_alu[DATA_W-1:0];
                    r_carry_pend <= w_carry;
                    r_we3        <= w_we;
                    r_wa3        <= r_rd;
                    r_done       <= 1'b1;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    r_we3      <= 1'b0;
                    r_done     <= 1'b0;
                    r_result   <= r_wd3;
                    r_carry    <= r_carry_pend;
                    r_zero     <= (r_wd3 == '0);
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_we3      <= 1'b0;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign ra1      = r_ra1;
    assign ra2      = r_ra2;
    assign we3      = r_we3;
    assign wa3      = r_wa3;
    assign wd3      = r_wd3;
    assign done     = r_done;
    assign result   = r_result;
    assign carry    = r_carry;
    assign zero     = r_zero;
endmodule

// File: tb/tb_alu_wb_sequencer.sv
// tb/tb_alu_wb_sequencer.sv - self-checking bench for alu_wb_sequencer with a behavioural RegisterFile
module tb_alu_wb_sequencer;
`ifdef ALU_SEQ_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [7:0] imm = '0;
    logic [2:0] ra1, ra2, wa3;
    logic [7:0] rd1, rd2, wd3, result;
    logic       we3, done, carry, zero;

    logic [7:0] rf [8];
    logic [7:0] mrf [8];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] g_wd3, g_result;
    logic [2:0] g_wa3, g_ra1, g_ra2;
    logic       g_we3, g_carry, g_zero, g_rdy_read, g_rdy_after;
    int         g_lat;

    always #5 clk = ~clk;

    alu_wb_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .done(done),
        .result(result), .carry(carry), .zero(zero)
    );

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];
    always @(posedge clk) if (we3) rf[wa3] <= wd3;

    typedef struct {
        logic [2:0] op, rd, rs1, rs2;
        logic [7:0] imm;
        logic [7:0] e_wd3;
        logic       e_c, e_z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] opnd(input logic [2:0] r);
        return (R0Z && r == 3'd0) ? 8'h00 : mrf[r];
    endfunction

    // Reference ALU in plain integer arithmetic.
    task automatic ref_exec(input logic [2:0] o, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [7:0] im, output logic [7:0] r, output logic c);
        int a, b, s;
        a = int'(opnd(s1));
        b = int'(opnd(s2));
        c = 1'b0;
        case (o)
            3'd0: begin s = a + b; r = 8'(s % 256); c = (s > 255); end
            3'd1: begin s = a - b + 256; r = 8'(s % 256); c = (a < b); end
            3'd2: r = 8'(a & b);
            3'd3: r = 8'(a | b);
            3'd4: r = 8'(a ^ b);
            3'd5: r = (a < b) ? 8'd1 : 8'd0;
            3'd6: r = im;
            default: r = 8'(a);
        endcase
    endtask

    task automatic do_instr(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                            input logic [2:0] s2, input logic [7:0] im);
        int w;
        @(negedge clk);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom); imm = 8'($urandom);
        g_lat = 0; g_we3 = 1'b0; g_wa3 = '0; g_wd3 = '0;
        for (int k = 1; k <= 8 && g_lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                g_rdy_read = in_ready; g_ra1 = ra1; g_ra2 = ra2;
            end
            if (done) begin
                g_lat = k; g_we3 = we3; g_wa3 = wa3; g_wd3 = wd3;
            end
        end
        @(negedge clk);
        g_rdy_after = in_ready; g_result = result; g_carry = carry; g_zero = zero;
    endtask

    task automatic run_check(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                             input logic [2:0] s2, input logic [7:0] im,
                             input logic [7:0] e_wd3, input logic e_c);
        logic e_we;
        e_we = !(R0Z && d == 3'd0);
        do_instr(o, d, s1, s2, im);
        chk("done_latency", g_lat, 3);
        chk("ready_in_read", g_rdy_read, 0);
        chk("ra1_in_read", g_ra1, s1);
        chk("ra2_in_read", g_ra2, s2);
        chk("we3", g_we3, e_we);
        chk("wa3", g_wa3, d);
        chk("wd3", g_wd3, e_wd3);
        chk("ready_after", g_rdy_after, 1);
        chk("result", g_result, e_wd3);
        chk("carry", g_carry, e_c);
        chk("zero", g_zero, e_wd3 == 8'h00);
        if (e_we) mrf[d] = e_wd3;
    endtask

    initial begin
        vec_t       tbl [7];
        logic [7:0] e_r;
        logic       e_c;
        int         hs, rdy_cnt, wr_cnt;

        tbl[0] = '{3'd6, 3'd1, 3'd0, 3'd0, 8'h0F, 8'h0F, 1'b0, 1'b0};
        tbl[1] = '{3'd6, 3'd2, 3'd0, 3'd0, 8'hF3, 8'hF3, 1'b0, 1'b0};
        tbl[2] = '{3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h02, 1'b1, 1'b0};
        tbl[3] = '{3'd1, 3'd4, 3'd1, 3'd2, 8'h00, 8'h1C, 1'b1, 1'b0};
        tbl[4] = '{3'd1, 3'd5, 3'd2, 3'd1, 8'h00, 8'hE4, 1'b0, 1'b0};
        tbl[5] = '{3'd4, 3'd6, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{3'd5, 3'd7, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_we3", we3, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ra1", ra1, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e_r = 8'($urandom);
            run_check(3'd6, 3'(i), 3'($urandom), 3'($urandom), e_r, (R0Z && i == 0) ? e_r : e_r, 1'b0);
        end
        if (R0Z) mrf[0] = 8'h00;

        for (int i = 0; i < 7; i++) begin
            run_check(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].e_wd3, tbl[i].e_c);
            chk("tbl_zero", g_zero, tbl[i].e_z);
        end

        run_check(3'd6, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0);
        run_check(3'd7, 3'd1, 3'd0, 3'd0, 8'h00, R0Z ? 8'h00 : 8'h55, 1'b0);

        // Back-to-back offers: only one in four cycles is accepted.
        @(negedge clk);
        op = 3'd6; rd = 3'd6; rs1 = 3'd0; rs2 = 3'd0; imm = 8'h3C; in_valid = 1'b1;
        hs = 0; rdy_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (in_ready) hs++;
            else rdy_cnt++;
            @(negedge clk);
            if (we3) wr_cnt++;
        end
        in_valid = 1'b0;
        chk("stream_handshakes", hs, 3);
        chk("stream_busy_cycles", rdy_cnt, 9);
        chk("stream_writes", wr_cnt, 3);
        mrf[6] = 8'h3C;
        @(negedge clk);
        chk("stream_idle", in_ready, 1);

        // Reset while ADD r3 is in EXEC.
        op = 3'd0; rd = 3'd3; rs1 = 3'd1; rs2 = 3'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_zero", zero, 1);
        chk("midrst_result", result, 0);
        wr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (we3 || done) wr_cnt++;
            @(negedge clk);
        end
        chk("midrst_no_write", wr_cnt, 0);
        chk("midrst_r3_kept", rf[3], mrf[3]);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o, d, s1, s2;
            logic [7:0] im;
            o = 3'($urandom); d = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom); im = 8'($urandom);
            ref_exec(o, s1, s2, im, e_r, e_c);
            run_check(o, d, s1, s2, im, e_r, e_c);
        end

        for (int i = 0; i < 8; i++)
            if (!(R0Z && i == 0)) chk("final_regfile", rf[i], mrf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end
endmodule
